// File: rtl/fifo_packer_if.sv
// Serial-in and FIFO-push signal bundle for fifo_packer.
// slave = the packer itself, master = whoever drives the serial bits and owns the FIFO.
interface fifo_packer_if #(parameter int W = 2);
    logic         sin;
    logic         sin_valid;
    logic         sin_ready;
    logic         full;
    logic         push;
    logic [W-1:0] data;

    modport slave  (input  sin, sin_valid, full,
                    output sin_ready, push, data);
    modport master (output sin, sin_valid, full,
                    input  sin_ready, push, data);
endinterface

// File: rtl/fifo_packer.sv
// Bit-serial (LSB first) to W-bit word packer feeding a FIFO push/in port, honouring full.
// Optional feature: define PARITY_EN for a trailing even-parity bit per word and parity_err.
module fifo_packer #(
    parameter int W  = 2,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    fifo_packer_if.slave  bus,
    output logic [CW-1:0] words_pushed
`ifdef PARITY_EN
    ,
    output logic          parity_err
`endif
);
    localparam int BW = $clog2(W);

    typedef enum logic [1:0] {COLLECT, PARITY, HOLD} state_t;

    state_t         state_q, state_d;
    logic [BW-1:0]  bitcnt_q, bitcnt_d;
    logic [W-1:0]   shreg_q, shreg_d;
    logic [W-1:0]   data_q, data_d;
    logic [CW-1:0]  cnt_q, cnt_d;
`ifdef PARITY_EN
    logic           perr_q, perr_d;
`endif
    logic           sin_ready;
    logic           push;
    logic           accept;

    // Handshake outputs are combinational so a falling full pushes in the same cycle.
    assign sin_ready = reset && (state_q != HOLD);
    assign push      = reset && (state_q == HOLD) && !bus.full;
    assign accept    = bus.sin_valid && sin_ready;

    assign bus.sin_ready = sin_ready;
    assign bus.push      = push;
    assign bus.data      = data_q;
    assign words_pushed  = cnt_q;
`ifdef PARITY_EN
    assign parity_err    = perr_q;
`endif

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
`ifdef PARITY_EN
        perr_d   = 1'b0;
`endif
        case (state_q)
            COLLECT: begin
                if (accept) begin
                    shreg_d[bitcnt_q] = bus.sin;
                    if (bitcnt_q == BW'(W-1)) begin
                        bitcnt_d = '0;
`ifdef PARITY_EN
                        state_d  = PARITY;
`else
                        data_d   = shreg_d;
                        state_d  = HOLD;
`endif
                    end else begin
                        bitcnt_d = bitcnt_q + BW'(1);
                    end
                end
            end
`ifdef PARITY_EN
            PARITY: begin
                if (accept) begin
                    // Even parity: word XOR parity bit must be zero; bad words never reach data.
                    if (^{bus.sin, shreg_q}) begin
                        perr_d  = 1'b1;
                        state_d = COLLECT;
                    end else begin
                        data_d  = shreg_q;
                        state_d = HOLD;
                    end
                end
            end
`endif
            HOLD: begin
                if (push) begin
                    cnt_d   = cnt_q + CW'(1);
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= COLLECT;
            bitcnt_q <= '0;
            shreg_q  <= '0;
            data_q   <= '0;
            cnt_q    <= '0;
`ifdef PARITY_EN
            perr_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            shreg_q  <= shreg_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
`ifdef PARITY_EN
            perr_q   <= perr_d;
`endif
        end
    end
endmodule

// File: tb/tb_fifo_packer.sv
// Scoreboard bench for fifo_packer (W=2, CW=8); expected words queued at send, popped on push.
module tb_fifo_packer;
    localparam int W  = 2;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [CW-1:0] words_pushed;
`ifdef PARITY_EN
    logic          parity_err;
`endif

    fifo_packer_if #(.W(W)) bus();

    fifo_packer #(.W(W), .CW(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus.slave),
        .words_pushed (words_pushed)
`ifdef PARITY_EN
        ,
        .parity_err   (parity_err)
`endif
    );

    always #5 clk = ~clk;

    int           errors = 0;
    int           checks = 0;
    int           npush  = 0;
    logic [W-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Every push is checked against the scoreboard and must never coincide with full.
    always @(negedge clk) begin
        if (bus.push === 1'b1) begin
            npush++;
            chk("push_while_full", {31'd0, bus.full}, 32'd0);
            if (exp_q.size() == 0) chk("unexpected_push", 32'd1, 32'd0);
            else                   chk("push_data", {30'd0, bus.data}, {30'd0, exp_q.pop_front()});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 right after the bit was accepted.
    task automatic send_bit(input logic b);
        logic rdy;
        int   n;
        bus.sin       = b;
        bus.sin_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            rdy = bus.sin_ready;
            @(posedge clk);
            n++;
        end while (!rdy && n < 50);
        #1;
        bus.sin_valid = 1'b0;
        if (!rdy) chk("bit_timeout", 32'd0, 32'd1);
    endtask

    // Sends one word (plus parity bit when enabled); ends on the negedge after the last accept.
    task automatic send_word(input logic [W-1:0] w, input logic bad);
        if (!bad) exp_q.push_back(w);
        for (int i = 0; i < W; i++) send_bit(w[i]);
`ifdef PARITY_EN
        send_bit((^w) ^ bad);
`endif
        @(negedge clk);
        chk("post_push", {31'd0, bus.push}, {31'd0, !bad && !bus.full});
        chk("post_ready", {31'd0, bus.sin_ready}, {31'd0, bad});
`ifdef PARITY_EN
        chk("post_perr", {31'd0, parity_err}, {31'd0, bad});
`endif
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", {31'd0, bus.sin_ready}, 32'd0);
        chk("rst_push", {31'd0, bus.push}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        int p0;
        reset         = 1'b1;
        bus.sin       = 1'b0;
        bus.sin_valid = 1'b0;
        bus.full      = 1'b0;
        step();

        // 1: reset, then word 11 pushed on the cycle after its last bit
        do_reset();
        @(negedge clk);
        chk("rst_words", {24'd0, words_pushed}, 32'd0);
        chk("rst_data", {30'd0, bus.data}, 32'd0);
        chk("rst_rdy_after", {31'd0, bus.sin_ready}, 32'd1);
`ifdef PARITY_EN
        chk("rst_perr", {31'd0, parity_err}, 32'd0);
`endif
        step();
        send_word(2'b11, 1'b0);
        step();
        @(negedge clk);
        chk("s1_push_once", {31'd0, bus.push}, 32'd0);
        chk("s1_ready_back", {31'd0, bus.sin_ready}, 32'd1);
        chk("s1_words", {24'd0, words_pushed}, 32'd1);
        step();

        // 2: word 01 held by full with sin_valid asserted the whole time
        bus.full = 1'b1;
        send_word(2'b01, 1'b0);
        bus.sin       = 1'b1;
        bus.sin_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("s2_hold_push", {31'd0, bus.push}, 32'd0);
            chk("s2_hold_ready", {31'd0, bus.sin_ready}, 32'd0);
            chk("s2_hold_data", {30'd0, bus.data}, 32'h1);
        end
        @(posedge clk);
        #1;
        bus.full      = 1'b0;
        bus.sin_valid = 1'b0;
        @(negedge clk);
        chk("s2_release_push", {31'd0, bus.push}, 32'd1);
        step();
        chk("s2_words", {24'd0, words_pushed}, 32'd2);

        // 3: gap of invalid cycles between bits
        exp_q.push_back(2'b10);
        send_bit(1'b0);
        repeat (3) begin
            @(negedge clk);
            chk("s3_gap_push", {31'd0, bus.push}, 32'd0);
        end
        step();
        send_bit(1'b1);
`ifdef PARITY_EN
        send_bit(1'b1);
`endif
        @(negedge clk);
        chk("s3_push", {31'd0, bus.push}, 32'd1);
        step();
        chk("s3_words", {24'd0, words_pushed}, 32'd3);

        // 4: reset mid-word discards the partial bit and clears the counter
        send_bit(1'b1);
        do_reset();
        chk("s4_words_rst", {24'd0, words_pushed}, 32'd0);
        send_word(2'b10, 1'b0);
        step();
        chk("s4_words", {24'd0, words_pushed}, 32'd1);

        // 5: 256 back-to-back words wrap the counter
        do_reset();
        p0 = npush;
        for (int k = 0; k < 256; k++) begin
            send_word(W'($urandom_range(0, 3)), 1'b0);
            step();
            if (k == 254) chk("s5_words_255", {24'd0, words_pushed}, 32'd255);
        end
        chk("s5_words_wrap", {24'd0, words_pushed}, 32'd0);
        chk("s5_push_count", npush - p0, 32'd256);

`ifdef PARITY_EN
        // 6: bad parity drops the word, good parity pushes it
        send_word(2'b01, 1'b1);
        step();
        chk("s6_perr_pulse", {31'd0, parity_err}, 32'd0);
        chk("s6_words_same", {24'd0, words_pushed}, 32'd0);
        send_word(2'b01, 1'b0);
        step();
        chk("s6_words", {24'd0, words_pushed}, 32'd1);
`endif

        repeat (2) step();
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
